shape_prep_scheduler: RTL

Sequences the single shared trig/rotate pre-processing path (angle to sin/cos, origin rotation to ix/iy) across all shape slots between frames. It keeps a per-shape dirty mask, so only shapes whose position or angle changed are recomputed. A pass starts on the frame-end strobe. For each selected shape the block drives operand-capture and result-write strobes to the shape register file in the control core.

---
 rtl/shape_prep_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/shape_prep_scheduler.sv
// shape_prep_scheduler
//
// Sequences the single shared trig/rotate pre-processing path across all
// shape slots between frames. A per-shape dirty mask records which slots had
// their position or angle changed; on the frame-end strobe a pass snapshots
// that mask and walks the selected slots in ascending index order. For each
// slot it issues an operand-capture strobe, waits LAT cycles for the shared
// path, and then issues a result-write strobe.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pass request (frame-end strobe)
//   mark_valid mark slot mark_id dirty this cycle
//   mark_id    slot index to mark
//   mark_all   mark every slot dirty this cycle
//   sel_id     slot whose operands feed the shared path / whose results are written
//   cap        one-cycle operand-capture strobe for sel_id
//   wr_en      one-cycle result-write strobe for sel_id
//   busy       pass in progress
//   done       one-cycle pulse at the end of a pass
//   overrun    sticky: start arrived while a pass was running
//   dirty      current dirty mask
module shape_prep_scheduler #(
    parameter int MAXSHP = 16,
    parameter int IDW    = 4,
    parameter int LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mark_valid,
    input  logic [IDW-1:0]    mark_id,
    input  logic              mark_all,
    output logic [IDW-1:0]    sel_id,
    output logic              cap,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [MAXSHP-1:0] dirty
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOAD,
        WAIT,
        WRITE,
        FIN
    } state_t;

    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    state_t            state_q, state_d;
    logic [MAXSHP-1:0] pend_q, pend_d;
    logic [MAXSHP-1:0] dirty_q, dirty_d;
    logic [IDW-1:0]    sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              overrun_q, overrun_d;

    logic [MAXSHP-1:0] mark_vec;
    logic [IDW-1:0]    low_idx;

    // All marks arriving this cycle, folded into one mask.
    always_comb begin
        mark_vec = '0;
        if (mark_valid) begin
            mark_vec = MAXSHP'(1) << mark_id;
        end
        if (mark_all) begin
            mark_vec = '1;
        end
    end

    // Lowest set bit of the pending mask; scanning downward lets the lowest
    // index overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int i = MAXSHP - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = IDW'(i);
            end
        end
    end

    // Next-state logic. Marks are OR-ed in after the LOAD clear so that a mark
    // colliding with the clear of the same slot keeps the slot dirty.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        dirty_d   = dirty_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pend_d  = dirty_q | mark_vec;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (pend_q == '0) begin
                    state_d = FIN;
                end else begin
                    sel_d   = low_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pend_d[sel_q]  = 1'b0;
                dirty_d[sel_q] = 1'b0;
                cnt_d          = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE: begin
                state_d = SCAN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dirty_d = dirty_d | mark_vec;

        if (start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State register. Reset leaves every slot dirty so the first pass after
    // reset recomputes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            dirty_q   <= '1;
            sel_q     <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            dirty_q   <= dirty_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign cap     = (state_q == LOAD);
    assign wr_en   = (state_q == WRITE);
    assign done    = (state_q == FIN);
    assign sel_id  = sel_q;
    assign overrun = overrun_q;
    assign dirty   = dirty_q;

endmodule
